// File: rtl/debug_resp_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : debug_resp_tx                                                 |
// | Purpose  : Response path of the UART register debugger. Takes one        |
// |            read-result byte, formats it as two uppercase ASCII hex       |
// |            characters followed by CR LF (or "ER" CR LF on error), and    |
// |            serializes each character on the TX line as 8N1, LSB first.   |
// | Ports    : clk          - system clock, rising-edge active               |
// |            rst_n        - asynchronous active-low reset                  |
// |            i_resp_valid - response request from the command decoder      |
// |            o_resp_ready - request accepted when high (IDLE only)         |
// |            i_resp_data  - register value to report                       |
// |            i_resp_err   - report "ER" instead of the hex digits          |
// |            o_uart_tx    - registered serial line, idle high              |
// |            o_busy       - frame in progress (~o_resp_ready)              |
// | Options  : DEBUG_RESP_PROMPT_EN - when defined, a '>' prompt character   |
// |            is appended after LF (5 characters per frame).                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module debug_resp_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_resp_valid,
  output logic       o_resp_ready,
  input  logic [7:0] i_resp_data,
  input  logic       i_resp_err,
  output logic       o_uart_tx,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  // Keep at least one counter bit so a degenerate 1-cycle bit still elaborates.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef DEBUG_RESP_PROMPT_EN
  localparam int CHR_W = 3;
  localparam logic [CHR_W-1:0] CHR_LAST = 3'd4;
`else
  localparam int CHR_W = 2;
  localparam logic [CHR_W-1:0] CHR_LAST = 2'd3;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q,  baud_d;
  logic [2:0]       bit_q,   bit_d;
  logic [CHR_W-1:0] chr_q,   chr_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q,  data_d;
  logic             err_q,   err_d;
  logic             tx_q,    tx_d;

  // ASCII uppercase hex digit.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n <= 4'd9) c = 8'h30 + {4'h0, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

  // Character at position idx of the response line.
  function automatic logic [7:0] char_at(input logic [CHR_W-1:0] idx,
                                         input logic [7:0]       data,
                                         input logic             err);
    logic [7:0] c;
    case (idx)
      CHR_W'(0): c = err ? 8'h45 : hex_char(data[7:4]);
      CHR_W'(1): c = err ? 8'h52 : hex_char(data[3:0]);
      CHR_W'(2): c = 8'h0D;
`ifdef DEBUG_RESP_PROMPT_EN
      CHR_W'(3): c = 8'h0A;
      default:   c = 8'h3E;
`else
      default:   c = 8'h0A;
`endif
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    chr_d   = chr_q;
    shift_d = shift_q;
    data_d  = data_q;
    err_d   = err_q;
    tx_d    = tx_q;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        chr_d  = '0;
        if (i_resp_valid) begin
          // Character 0 comes straight from the inputs so the start bit can
          // be driven on the handshake edge itself.
          data_d  = i_resp_data;
          err_d   = i_resp_err;
          shift_d = char_at('0, i_resp_data, i_resp_err);
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (baud_q == CNT_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_q == CNT_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (baud_q == CNT_LAST) begin
          baud_d = '0;
          if (chr_q == CHR_LAST) begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end else begin
            // Next character starts immediately: no idle gap inside a line.
            chr_d   = chr_q + CHR_W'(1);
            shift_d = char_at(chr_q + CHR_W'(1), data_q, err_q);
            tx_d    = 1'b0;
            state_d = START;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      chr_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      chr_q   <= chr_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
    end
  end

  assign o_resp_ready = (state_q == IDLE);
  assign o_busy       = ~o_resp_ready;
  assign o_uart_tx    = tx_q;

endmodule
`default_nettype wire
